// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth MAC datapath.
// States, default widths and saturation bounds used by the accumulator.
package booth_pkg;

  localparam int PROD_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Signed adder with overflow detect; clamps when BOOTH_ACC_SATURATE_EN
// is defined, otherwise wraps modulo 2**W.
module booth_sat_add
  import booth_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W-1:0] raw;

  assign raw = a + b;
  assign ovf = (a[W-1] == b[W-1]) &&
               (raw[W-1] != a[W-1]);

`ifdef BOOTH_ACC_SATURATE_EN
  localparam logic [W-1:0] MAX_V = W'(sat_max(W));
  localparam logic [W-1:0] MIN_V = W'(sat_min(W));

  // both operands share a sign on overflow, so a's sign picks the rail
  assign sum = !ovf    ? raw   :
               a[W-1]  ? MIN_V : MAX_V;
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/booth_product_accumulator.sv
// Sums a job of LEN signed products into a wide accumulator.
// Build option BOOTH_ACC_SATURATE_EN selects clamping instead of wrap.
module booth_product_accumulator
  import booth_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = 16,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] product,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              busy,
  output logic              overflow
);

  acc_state_t state, state_n;

  logic [ACC_W-1:0] acc, acc_n;
  logic [ACC_W-1:0] ext, sum;
  logic             ovf_r, ovf_n, add_ovf;
  logic [LEN_W-1:0] rem, rem_n;

  logic signed [PROD_W-1:0] prod_s;

  assign prod_s = product;
  assign ext    = ACC_W'(prod_s);

  booth_sat_add #(.W(ACC_W)) u_add (
    .a   (acc),
    .b   (ext),
    .sum (sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      ovf_r <= 1'b0;
      rem   <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      ovf_r <= ovf_n;
      rem   <= rem_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    ovf_n   = ovf_r;
    rem_n   = rem;
    case (state)
      IDLE: begin
        if (start) begin
          acc_n   = '0;
          ovf_n   = 1'b0;
          rem_n   = len;
          state_n = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (prod_valid) begin
          acc_n = sum;
          ovf_n = ovf_r | add_ovf;
          rem_n = rem - 1'b1;
          if (rem == LEN_W'(1))
            state_n = DONE;
        end
      end
      DONE: begin
        if (acc_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign prod_ready = (state == ACCUM);
  assign acc_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign acc_out    = acc;
  assign overflow   = ovf_r;

endmodule
